// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//   Bridges the RV32I execute stage and a byte-addressed synchronous data
//   memory with one cycle of read latency. Decodes load/store funct3, drives
//   the memory strobes, address, addressable unit and write data, and returns
//   sign/zero-extended load data. Requests outside the memory, requests whose
//   access would wrap past the top of memory, and undefined funct3 encodings
//   are rejected without touching memory. Exactly one response is returned
//   per accepted request.
//
// Configuration:
//   LSU_MISALIGN_TRAP_EN  when defined, halfword accesses with addr[0]!=0 and
//                         word accesses with addr[1:0]!=0 are rejected. When
//                         undefined (default) they go to memory unchanged.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous, active-high reset
//   req_valid_i      request present
//   req_ready_o      LSU can accept (high only in IDLE, combinational)
//   req_write_i      1 = store, 0 = load
//   req_funct3_i     RV32I funct3 of the load/store
//   req_addr_i       byte address
//   req_wdata_i      store data (low bits used for SB/SH)
//   resp_valid_o     one-cycle response pulse
//   resp_err_o       request rejected, no memory access made
//   resp_rdata_o     extended load data; 0 for stores and errors
//   mem_read_o       memory read strobe
//   mem_write_o      memory write strobe
//   mem_addr_unit_o  memory addressable unit (00 byte, 01 half, 10 word)
//   mem_address_o    memory byte address
//   mem_wdata_o      memory write data
//   mem_rdata_i      memory read data (valid the cycle after mem_read_o)
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [31:0]           req_addr_i,
    input  logic [WORD_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    output logic                  resp_err_o,
    output logic [WORD_WIDTH-1:0] resp_rdata_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [1:0]            mem_addr_unit_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic [WORD_WIDTH-1:0] mem_wdata_o,
    input  logic [WORD_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        LWAIT  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    write_q;
    logic [2:0]              funct3_q;
    logic                    resp_valid_q;
    logic                    resp_err_q;
    logic [WORD_WIDTH-1:0]   resp_rdata_q;
    logic                    mem_read_q;
    logic                    mem_write_q;
    logic [1:0]              mem_addr_unit_q;
    logic [ADDR_WIDTH-1:0]   mem_address_q;
    logic [WORD_WIDTH-1:0]   mem_wdata_q;

    logic                    req_illegal;
    logic [1:0]              span;      // access size in bytes, minus one
    logic [ADDR_WIDTH:0]     end_addr;  // last byte touched, with carry
    logic [WORD_WIDTH-1:0]   rdata_d;

    assign req_ready_o     = (state_q == IDLE);
    assign resp_valid_o    = resp_valid_q;
    assign resp_err_o      = resp_err_q;
    assign resp_rdata_o    = resp_rdata_q;
    assign mem_read_o      = mem_read_q;
    assign mem_write_o     = mem_write_q;
    assign mem_addr_unit_o = mem_addr_unit_q;
    assign mem_address_o   = mem_address_q;
    assign mem_wdata_o     = mem_wdata_q;

    // Request legality, evaluated on the incoming request while in IDLE.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        req_illegal = 1'b0;
        span        = 2'd0;

        if (req_write_i) begin
            req_illegal = (req_funct3_i >= 3'b011);
        end else begin
            req_illegal = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11);
        end

        // Address bits above the memory must be zero.
        if ((req_addr_i >> ADDR_WIDTH) != 32'd0) begin
            req_illegal = 1'b1;
        end

        case (req_funct3_i[1:0])
            2'b01:   span = 2'd1;
            2'b10:   span = 2'd3;
            default: span = 2'd0;
        endcase

        // A carry out of the memory address range means the access wraps.
        end_addr = {1'b0, req_addr_i[ADDR_WIDTH-1:0]} + {{(ADDR_WIDTH-1){1'b0}}, span};
        if (end_addr[ADDR_WIDTH]) begin
            req_illegal = 1'b1;
        end

`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
            (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00)) begin
            req_illegal = 1'b1;
        end
`endif
    end

    // Load data extension; only the low byte/halfword is used for narrow loads.
    always_comb begin
        rdata_d = mem_rdata_i;
        case (funct3_q)
            3'b000:  rdata_d = {{(WORD_WIDTH-8){mem_rdata_i[7]}},   mem_rdata_i[7:0]};
            3'b001:  rdata_d = {{(WORD_WIDTH-16){mem_rdata_i[15]}}, mem_rdata_i[15:0]};
            3'b100:  rdata_d = {{(WORD_WIDTH-8){1'b0}},             mem_rdata_i[7:0]};
            3'b101:  rdata_d = {{(WORD_WIDTH-16){1'b0}},            mem_rdata_i[15:0]};
            default: rdata_d = mem_rdata_i;
        endcase
    end

    // Control FSM with registered outputs. Memory-side outputs are non-zero
    // only during ACCESS, so the memory never sees a stale address or strobe.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            write_q         <= 1'b0;
            funct3_q        <= 3'b000;
            resp_valid_q    <= 1'b0;
            resp_err_q      <= 1'b0;
            resp_rdata_q    <= '0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_addr_unit_q <= 2'b00;
            mem_address_q   <= '0;
            mem_wdata_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        write_q  <= req_write_i;
                        funct3_q <= req_funct3_i;
                        if (req_illegal) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            mem_read_q      <= ~req_write_i;
                            mem_write_q     <= req_write_i;
                            mem_addr_unit_q <= req_funct3_i[1:0];
                            mem_address_q   <= req_addr_i[ADDR_WIDTH-1:0];
                            mem_wdata_q     <= req_wdata_i;
                            state_q         <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    mem_read_q      <= 1'b0;
                    mem_write_q     <= 1'b0;
                    mem_addr_unit_q <= 2'b00;
                    mem_address_q   <= '0;
                    mem_wdata_q     <= '0;
                    if (write_q) begin
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        state_q      <= LWAIT;
                    end
                end
                LWAIT: begin
                    resp_rdata_q <= rdata_d;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed testbench for load_store_unit with a byte-addressed synchronous
// memory model (1-cycle read latency, little-endian, returns four bytes from
// the requested address so narrow loads see non-zero upper bits).
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int AW = 10;
    localparam int MEM_BYTES = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_err;
    logic [31:0]   resp_rdata;
    logic          mem_read;
    logic          mem_write;
    logic [1:0]    mem_addr_unit;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem_model [MEM_BYTES];

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(AW), .WORD_WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_write_i     (req_write),
        .req_funct3_i    (req_funct3),
        .req_addr_i      (req_addr),
        .req_wdata_i     (req_wdata),
        .resp_valid_o    (resp_valid),
        .resp_err_o      (resp_err),
        .resp_rdata_o    (resp_rdata),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .mem_addr_unit_o (mem_addr_unit),
        .mem_address_o   (mem_address),
        .mem_wdata_o     (mem_wdata),
        .mem_rdata_i     (mem_rdata)
    );

    // Synchronous byte-addressed memory model.
    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem_model[i] = 8'h00;
        mem_rdata = 32'h0;
    end

    always @(posedge clk) begin
        if (mem_write) begin
            mem_model[mem_address] <= mem_wdata[7:0];
            if (mem_addr_unit != 2'b00) mem_model[AW'(mem_address + 1)] <= mem_wdata[15:8];
            if (mem_addr_unit == 2'b10) begin
                mem_model[AW'(mem_address + 2)] <= mem_wdata[23:16];
                mem_model[AW'(mem_address + 3)] <= mem_wdata[31:24];
            end
        end
        if (mem_read) begin
            mem_rdata <= {mem_model[AW'(mem_address + 3)], mem_model[AW'(mem_address + 2)],
                          mem_model[AW'(mem_address + 1)], mem_model[mem_address]};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request: drive, accept, then watch up to 10 cycles for the response.
    task automatic txn(input string tag, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_rd, input int exp_lat);
        int lat;
        int strobes;
        bit seen;
        lat = 0;
        strobes = 0;
        seen = 1'b0;
        @(negedge clk);
        check({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            lat++;
            if (mem_read && mem_write) check({tag, " both_strobes"}, 32'd1, 32'd0);
            if (mem_read || mem_write) begin
                strobes++;
                check({tag, " strobe_kind"}, {31'd0, mem_write}, {31'd0, wr});
                check({tag, " mem_addr"}, {{(32-AW){1'b0}}, mem_address}, {{(32-AW){1'b0}}, addr[AW-1:0]});
                check({tag, " mem_unit"}, {30'd0, mem_addr_unit}, {30'd0, f3[1:0]});
                if (wr) check({tag, " mem_wdata"}, mem_wdata, wd);
            end
            if (resp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check({tag, " timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, " latency"}, lat, exp_lat);
            check({tag, " err"}, {31'd0, resp_err}, {31'd0, exp_err});
            check({tag, " rdata"}, resp_rdata, exp_rd);
            check({tag, " strobes"}, strobes, exp_err ? 32'd0 : 32'd1);
            @(negedge clk);
            check({tag, " resp_drop"}, {31'd0, resp_valid}, 32'd0);
            check({tag, " ready_back"}, {31'd0, req_ready}, 32'd1);
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        check("rst ready",      {31'd0, req_ready},  32'd1);
        check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst mem_read",   {31'd0, mem_read},   32'd0);
        check("rst mem_write",  {31'd0, mem_write},  32'd0);
        check("rst rdata",      resp_rdata,          32'd0);
        rst = 1'b0;

        // Word store then narrow loads of its bytes/halfwords.
        txn("sw10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0,        2);
        txn("lb13",  1'b0, 3'b000, 32'h13, 32'h0,        1'b0, 32'hFFFFFFDE, 3);
        txn("lbu13", 1'b0, 3'b100, 32'h13, 32'h0,        1'b0, 32'h000000DE, 3);
        txn("lh10",  1'b0, 3'b001, 32'h10, 32'h0,        1'b0, 32'hFFFFBEEF, 3);
        txn("lhu10", 1'b0, 3'b101, 32'h10, 32'h0,        1'b0, 32'h0000BEEF, 3);
        txn("lw10",  1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 3);

        // Byte store over a zero word touches only the low byte.
        txn("sw20",  1'b1, 3'b010, 32'h20, 32'h00000000, 1'b0, 32'h0,        2);
        txn("sb20",  1'b1, 3'b000, 32'h20, 32'h123456A5, 1'b0, 32'h0,        2);
        txn("lw20",  1'b0, 3'b010, 32'h20, 32'h0,        1'b0, 32'h000000A5, 3);

        // Halfword store, then word and signed halfword reads.
        txn("sh30",  1'b1, 3'b001, 32'h30, 32'hFFFF8001, 1'b0, 32'h0,        2);
        txn("lw30",  1'b0, 3'b010, 32'h30, 32'h0,        1'b0, 32'h00008001, 3);
        txn("lh30",  1'b0, 3'b001, 32'h30, 32'h0,        1'b0, 32'hFFFF8001, 3);

        // Top-of-memory boundary.
        txn("sw3fc", 1'b1, 3'b010, 32'h3FC, 32'hCAFEF00D, 1'b0, 32'h0,        2);
        txn("lw3fc", 1'b0, 3'b010, 32'h3FC, 32'h0,        1'b0, 32'hCAFEF00D, 3);
        txn("lb3ff", 1'b0, 3'b000, 32'h3FF, 32'h0,        1'b0, 32'hFFFFFFCA, 3);
        txn("lw3fe", 1'b0, 3'b010, 32'h3FE, 32'h0,        1'b1, 32'h0,        1);
        txn("lh3ff", 1'b0, 3'b001, 32'h3FF, 32'h0,        1'b1, 32'h0,        1);

        // Out-of-range addresses.
        txn("lw_hi", 1'b0, 3'b010, 32'h80000000, 32'h0,   1'b1, 32'h0,        1);
        txn("lw400", 1'b0, 3'b010, 32'h400,      32'h0,   1'b1, 32'h0,        1);
        txn("sw400", 1'b1, 3'b010, 32'h400,      32'h1,   1'b1, 32'h0,        1);

        // Undefined funct3 encodings.
        txn("ld011", 1'b0, 3'b011, 32'h10, 32'h0,        1'b1, 32'h0,        1);
        txn("ld110", 1'b0, 3'b110, 32'h10, 32'h0,        1'b1, 32'h0,        1);
        txn("st100", 1'b1, 3'b100, 32'h10, 32'h55555555, 1'b1, 32'h0,        1);
        txn("lw10b", 1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 3);

        // Misaligned halfword: bytes 0x12 (high) and 0x11 (low) = 0xADBE.
`ifdef LSU_MISALIGN_TRAP_EN
        txn("lh11",  1'b0, 3'b001, 32'h11, 32'h0,        1'b1, 32'h0,        1);
`else
        txn("lh11",  1'b0, 3'b001, 32'h11, 32'h0,        1'b0, 32'hFFFFADBE, 3);
`endif

        // Reset in the middle of a store's ACCESS cycle.
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        req_wdata  = 32'h11223344;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        @(negedge clk);
        check("rstmid mem_write_before", {31'd0, mem_write}, 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid mem_write_drop", {31'd0, mem_write}, 32'd0);
        check("rstmid resp_valid",     {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rstmid no_resp", {31'd0, resp_valid}, 32'd0);
            check("rstmid ready",   {31'd0, req_ready},  32'd1);
        end
        txn("lw40",  1'b0, 3'b010, 32'h40, 32'h0,        1'b0, 32'h00000000, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
